// File: rtl/icache_axi_rd_bridge_pkg.sv
// Shared types and derivation helpers for the icache AXI refill bridge.
package icache_axi_rd_bridge_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } bridge_state_e;

    function automatic int unsigned calc_beats(input int unsigned line_bytes,
                                               input int unsigned data_w);
        return (line_bytes * 8) / data_w;
    endfunction

    function automatic int unsigned calc_off_w(input int unsigned line_bytes);
        return $clog2(line_bytes);
    endfunction

    // Counter needs at least one bit even for single-beat lines.
    function automatic int unsigned calc_cnt_w(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/icache_axi_rd_bridge.sv
// Icache miss refill engine: one line request becomes one AXI4 INCR read burst,
// beats are forwarded to the cache and assembled into a line with a sticky error.
module icache_axi_rd_bridge
    import icache_axi_rd_bridge_pkg::*;
#(
    parameter int unsigned     ADDR_W     = 32,
    parameter int unsigned     DATA_W     = 64,
    parameter int unsigned     LINE_BYTES = 16,
    parameter int unsigned     ID_W       = 4,
    parameter logic [ID_W-1:0] AXI_ID     = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_req,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic                    rd_ready,
    output logic                    beat_valid,
    output logic                    beat_last,
    output logic [1:0]              beat_resp,
    output logic [DATA_W-1:0]       beat_data,
    output logic                    line_valid,
    output logic [LINE_BYTES*8-1:0] line_data,
    output logic                    line_err,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [ADDR_W-1:0]       araddr,
    output logic [ID_W-1:0]         arid,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [DATA_W-1:0]       rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic [ID_W-1:0]         rid
);

    localparam int unsigned       BEATS     = calc_beats(LINE_BYTES, DATA_W);
    localparam int unsigned       LINE_W    = LINE_BYTES * 8;
    localparam int unsigned       OFF_W     = calc_off_w(LINE_BYTES);
    localparam int unsigned       CNT_W     = calc_cnt_w(BEATS);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);

    bridge_state_e     state_q, state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              line_valid_q, line_valid_d;
    logic              line_err_q, line_err_d;
    logic              beat_err;

    // A beat is faulty on a bad response, a foreign ID, or rlast not matching the final slot.
    always_comb begin
        beat_err = (rresp != AXI_RESP_OKAY) | (rid != AXI_ID) | (rlast != (cnt_q == CNT_MAX));
    end

    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        line_d       = line_q;
        line_valid_d = 1'b0;
        line_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    araddr_d = rd_addr & LINE_MASK;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    state_d  = ST_AR;
                end
            end
            ST_AR: begin
                if (arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (rvalid) begin
                    // Saturating counter: overrun beats keep landing in the last slot.
                    for (int unsigned k = 0; k < BEATS; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            line_d[k*DATA_W +: DATA_W] = rdata;
                        end
                    end
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    err_d = err_q | beat_err;
                    if (rlast) begin
                        state_d      = ST_DONE;
                        line_valid_d = 1'b1;
                        line_err_d   = err_q | beat_err;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            araddr_q     <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            line_q       <= '0;
            line_valid_q <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            line_q       <= line_d;
            line_valid_q <= line_valid_d;
            line_err_q   <= line_err_d;
        end
    end

    // Handshake strobes are straight decodes of the state register.
    assign rd_ready   = (state_q == ST_IDLE);
    assign arvalid    = (state_q == ST_AR);
    assign rready     = (state_q == ST_R);
    assign araddr     = araddr_q;
    assign arid       = AXI_ID;
    assign arlen      = 8'(BEATS - 1);
    assign arsize     = 3'($clog2(DATA_W / 8));
    assign arburst    = AXI_BURST_INCR;

    assign beat_valid = rvalid & rready;
    assign beat_last  = rlast;
    assign beat_resp  = rresp;
    assign beat_data  = rdata;

    assign line_valid = line_valid_q;
    assign line_data  = line_q;
    assign line_err   = line_err_q;

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Self-checking bench for icache_axi_rd_bridge: vector table of refill bursts plus
// hand sequences for reset mid-burst and a request held across DONE.
module tb_icache_axi_rd_bridge;
    import icache_axi_rd_bridge_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned LINE_BYTES = 16;
    localparam int unsigned ID_W = 4;
    localparam int unsigned BEATS = 2;
    localparam int unsigned LINE_W = LINE_BYTES * 8;
    localparam int unsigned CW = 128;
    localparam int unsigned NVEC = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              beat_valid;
    logic              beat_last;
    logic [1:0]        beat_resp;
    logic [DATA_W-1:0] beat_data;
    logic              line_valid;
    logic [LINE_W-1:0] line_data;
    logic              line_err;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [ID_W-1:0]   rid;

    always #5 clk = ~clk;

    icache_axi_rd_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_BYTES(LINE_BYTES), .ID_W(ID_W), .AXI_ID(4'h0)
    ) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .beat_valid(beat_valid), .beat_last(beat_last), .beat_resp(beat_resp),
        .beat_data(beat_data), .line_valid(line_valid), .line_data(line_data),
        .line_err(line_err), .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst), .rvalid(rvalid),
        .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] exp_araddr;
        int                nbeats;
        int                last_at;
        int                resp_beat;
        logic [1:0]        resp;
        int                bad_id_beat;
        int                ar_wait;
        int                r_gap;
        logic              exp_err;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    typedef struct {
        logic [LINE_W-1:0] line;
        logic              err;
    } line_t;

    vec_t              vecs[NVEC];
    beat_t             beat_q[$];
    line_t             line_q[$];
    beat_t             eb;
    line_t             el;
    logic [LINE_W-1:0] model_line;
    int                n_chk = 0;
    int                n_fail = 0;
    int                cyc = 0;
    int                line_cyc = -1;
    int                acc0;
    int                acc1;
    int                prev_line;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: beats and lines are popped as the DUT presents them.
    always @(negedge clk) begin
        if (beat_q.size() == 0) begin
            if (beat_valid) chk("beat_valid_unexpected", CW'(beat_valid), CW'(0));
        end else begin
            eb = beat_q.pop_front();
            chk("beat_valid", CW'(beat_valid), CW'(1));
            if (beat_valid) begin
                chk("beat_data", CW'(beat_data), CW'(eb.data));
                chk("beat_resp", CW'(beat_resp), CW'(eb.resp));
                chk("beat_last", CW'(beat_last), CW'(eb.last));
            end
        end
        if (line_valid) begin
            if (line_q.size() == 0) begin
                chk("line_valid_unexpected", CW'(line_valid), CW'(0));
            end else begin
                el = line_q.pop_front();
                chk("line_data", CW'(line_data), CW'(el.line));
                chk("line_err", CW'(line_err), CW'(el.err));
                chk("rd_ready_in_done", CW'(rd_ready), CW'(0));
                line_cyc = cyc;
            end
        end
    end

    task automatic run_txn(input vec_t v, input bit hold, output int acc_cyc);
        int  exp_line_cyc;
        int  idx;
        bit  got;
        rd_req  = 1'b1;
        rd_addr = v.addr;
        acc_cyc = -1;
        got     = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rd_ready) got = 1'b1;
            else step();
        end
        if (!got) begin
            chk("rd_ready_timeout", CW'(rd_ready), CW'(1));
            return;
        end
        acc_cyc = cyc;
        step();
        if (!hold) begin
            rd_req  = 1'b0;
            rd_addr = ~v.addr;
        end
        // Stray R traffic while AR is pending must be ignored.
        for (int i = 0; i < v.ar_wait; i++) begin
            rvalid = 1'b1; rdata = '1; rlast = 1'b1; rid = '0; rresp = AXI_RESP_OKAY;
            chk("arvalid_wait", CW'(arvalid), CW'(1));
            chk("araddr_wait", CW'(araddr), CW'(v.exp_araddr));
            chk("rready_wait", CW'(rready), CW'(0));
            chk("rd_ready_busy", CW'(rd_ready), CW'(0));
            step();
        end
        rvalid  = 1'b0;
        arready = 1'b1;
        chk("arvalid", CW'(arvalid), CW'(1));
        chk("araddr", CW'(araddr), CW'(v.exp_araddr));
        chk("arlen", CW'(arlen), CW'(8'd1));
        chk("arsize", CW'(arsize), CW'(3'd3));
        chk("arburst", CW'(arburst), CW'(2'b01));
        chk("arid", CW'(arid), CW'(4'h0));
        step();
        arready = 1'b0;
        for (int b = 0; b < v.nbeats; b++) begin
            if (b > 0) begin
                for (int g = 0; g < v.r_gap; g++) begin
                    rvalid = 1'b0;
                    chk("rready_gap", CW'(rready), CW'(1));
                    step();
                end
            end
            rvalid = 1'b1;
            rdata  = {$urandom, $urandom};
            rresp  = (b == v.resp_beat) ? v.resp : AXI_RESP_OKAY;
            rid    = (b == v.bad_id_beat) ? 4'h5 : 4'h0;
            rlast  = (b == v.last_at);
            beat_q.push_back('{rdata, rresp, rlast});
            idx = (b < int'(BEATS)) ? b : int'(BEATS) - 1;
            model_line[idx*DATA_W +: DATA_W] = rdata;
            if (rlast) line_q.push_back('{model_line, v.exp_err});
            step();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        exp_line_cyc = acc_cyc + 2 + v.ar_wait + v.r_gap * (v.nbeats - 1) + v.nbeats;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (line_q.size() == 0) got = 1'b1;
            else step();
        end
        if (!got) begin
            chk("line_timeout", CW'(line_q.size()), CW'(0));
            line_q.delete();
        end
        chk("line_latency", CW'(line_cyc), CW'(exp_line_cyc));
        chk("rd_ready_after", CW'(rd_ready), CW'(1));
        chk("beat_q_drained", CW'(beat_q.size()), CW'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        //        addr           araddr         nb last rbeat resp   idb arw gap err
        vecs[0] = '{32'h8000_1234, 32'h8000_1230, 2, 1, -1, 2'b00, -1, 0, 0, 1'b0};
        vecs[1] = '{32'h0000_0FFF, 32'h0000_0FF0, 2, 1, -1, 2'b00, -1, 5, 0, 1'b0};
        vecs[2] = '{32'h1234_567C, 32'h1234_5670, 2, 1,  1, 2'b10, -1, 0, 0, 1'b1};
        vecs[3] = '{32'hDEAD_BEE8, 32'hDEAD_BEE0, 1, 0, -1, 2'b00, -1, 0, 0, 1'b1};
        vecs[4] = '{32'h0000_0010, 32'h0000_0010, 2, 1, -1, 2'b00,  0, 0, 0, 1'b1};
        vecs[5] = '{32'hFFFF_FFF3, 32'hFFFF_FFF0, 2, 1, -1, 2'b00, -1, 0, 3, 1'b0};
        vecs[6] = '{32'h2000_0008, 32'h2000_0000, 3, 2, -1, 2'b00, -1, 1, 0, 1'b1};
        vecs[7] = '{32'h3333_3333, 32'h3333_3330, 2, 1,  0, 2'b01, -1, 0, 0, 1'b1};
        vecs[8] = '{32'h7654_321F, 32'h7654_3210, 2, 1,  1, 2'b11, -1, 2, 1, 1'b1};

        rst = 1'b1; rd_req = 1'b0; rd_addr = '0; arready = 1'b0;
        rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
        model_line = '0;
        step(); step(); step();
        rst = 1'b0;
        chk("rst_rd_ready", CW'(rd_ready), CW'(1));
        chk("rst_arvalid", CW'(arvalid), CW'(0));
        chk("rst_rready", CW'(rready), CW'(0));
        chk("rst_line_valid", CW'(line_valid), CW'(0));
        chk("rst_line_err", CW'(line_err), CW'(0));
        chk("rst_line_data", CW'(line_data), CW'(0));
        chk("rst_araddr", CW'(araddr), CW'(0));

        for (int i = 0; i < int'(NVEC); i++) begin
            run_txn(vecs[i], 1'b0, acc0);
        end

        // Request held through DONE is taken only in the following IDLE cycle.
        run_txn(vecs[0], 1'b1, acc0);
        prev_line = line_cyc;
        run_txn(vecs[5], 1'b0, acc1);
        chk("held_req_accept", CW'(acc1), CW'(prev_line + 1));

        // Reset after one beat abandons the burst with no line pulse.
        rd_req = 1'b1; rd_addr = 32'h4000_0044;
        step();
        rd_req = 1'b0;
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid = 1'b1; rdata = {$urandom, $urandom}; rresp = AXI_RESP_OKAY; rid = '0; rlast = 1'b0;
        beat_q.push_back('{rdata, rresp, rlast});
        step();
        rvalid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_line = '0;
        chk("midrst_rd_ready", CW'(rd_ready), CW'(1));
        chk("midrst_arvalid", CW'(arvalid), CW'(0));
        chk("midrst_rready", CW'(rready), CW'(0));
        chk("midrst_line_valid", CW'(line_valid), CW'(0));
        chk("midrst_line_data", CW'(line_data), CW'(0));
        step();
        chk("midrst_no_line", CW'(line_valid), CW'(0));

        run_txn(vecs[2], 1'b0, acc0);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
